// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared encodings for the pipeline control unit: counter-select indices and
// recovery FSM states.
package pipe_ctrl_unit_pkg;

  localparam int CNT_STALL   = 0;
  localparam int CNT_PRMISS  = 1;
  localparam int CNT_RECOV   = 2;
  localparam int CNT_FU_BASE = 3;

  // Recovery hold counter covers RECOV_CYCLES in 0..15.
  localparam int RC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_RECOVER = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                  q_d = '0;
    else if (inc && ~&q_q)    q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Front-end stall/kill generation, per-FU issue grants, mispredict recovery
// sequencing and saturating performance counters.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NUM_FU       = 4,
  parameter int RECOV_CYCLES = 2,
  parameter int CNT_W        = 32,
  parameter int SEL_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_dp_freelist_allocable,
  input  logic [NUM_FU-1:0] i_dp_rs_allocable,
  input  logic              i_exfin_prmiss,
  input  logic [NUM_FU-1:0] i_is_rs_sel_vld,
  input  logic [NUM_FU-1:0] i_ex_accessable,
  output logic              o_if_kill,
  output logic              o_id_kill,
  output logic              o_dp_kill,
  output logic              o_if_stall,
  output logic              o_id_stall,
  output logic              o_dp_stall,
  output logic [NUM_FU-1:0] o_is_rs_vld,
  output logic              o_recovering,
  input  logic [SEL_W-1:0]  i_cnt_sel,
  output logic [CNT_W-1:0]  o_cnt_val,
  input  logic              i_cnt_clr
);

  localparam int NCNT = NUM_FU + CNT_FU_BASE;

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              recov_q;
  logic              res_stall, kill, stall;

  logic [NCNT-1:0]             cnt_inc;
  logic [NCNT-1:0][CNT_W-1:0]  cnt_q;

  assign res_stall = !(i_dp_freelist_allocable && &i_dp_rs_allocable);
  assign kill      = i_exfin_prmiss || (state_q == S_FLUSH);
  assign stall     = res_stall || (state_q == S_RECOVER);

  assign o_if_kill  = kill;
  assign o_id_kill  = kill;
  assign o_dp_kill  = kill;
  assign o_if_stall = stall;
  assign o_id_stall = stall;
  assign o_dp_stall = stall;

  // Back-end squash is by tag, so issue ignores the recovery state.
  assign o_is_rs_vld  = i_is_rs_sel_vld & i_ex_accessable;
  assign o_recovering = recov_q;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE: ;
      S_FLUSH: begin
        rcnt_d  = RC_W'(RECOV_CYCLES);
        state_d = (RECOV_CYCLES == 0) ? S_IDLE : S_RECOVER;
      end
      S_RECOVER: begin
        rcnt_d = rcnt_q - RC_W'(1);
        if (rcnt_q <= RC_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A new mispredict restarts the whole sequence from any state.
    if (i_exfin_prmiss) state_d = S_FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      recov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      recov_q <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    cnt_inc                         = '0;
    cnt_inc[CNT_STALL]              = stall && !kill;
    cnt_inc[CNT_PRMISS]             = i_exfin_prmiss;
    cnt_inc[CNT_RECOV]              = (state_q != S_IDLE);
    cnt_inc[CNT_FU_BASE +: NUM_FU]  = i_is_rs_sel_vld & ~i_ex_accessable;
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (i_cnt_clr),
      .inc   (cnt_inc[g]),
      .q     (cnt_q[g])
    );
  end

  always_comb begin
    o_cnt_val = '0;
    for (int k = 0; k < NCNT; k++)
      if (i_cnt_sel == SEL_W'(k)) o_cnt_val = cnt_q[k];
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomised + directed bench for pipe_ctrl_unit; three builds share stimulus:
// default, RECOV_CYCLES=0 and CNT_W=4.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

  localparam int NF = 4;
  localparam int NC = NF + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fl = 1'b1, miss = 1'b0, clr = 1'b0;
  logic [NF-1:0] rs = '1, sv = '0, ex = '1;
  logic [2:0]    sel = '0;

  logic [2:0]         if_k, id_k, dp_k, if_s, id_s, dp_s, recov;
  logic [2:0][NF-1:0] isv;
  logic [31:0]        cv0, cv1;
  logic [3:0]         cv2;

  int n_chk = 0, n_fail = 0;

  // Reference model: recovery timeline derived from the cycle of the last miss.
  int     cyc = 0;
  int     last_miss = -100;
  int     rc[3] = '{2, 0, 2};
  longint mx[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  longint mcnt[3][NC];

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.NUM_FU(NF), .RECOV_CYCLES(2), .CNT_W(32), .SEL_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_dp_freelist_allocable(fl), .i_dp_rs_allocable(rs),
    .i_exfin_prmiss(miss), .i_is_rs_sel_vld(sv), .i_ex_accessable(ex),
    .o_if_kill(if_k[0]), .o_id_kill(id_k[0]), .o_dp_kill(dp_k[0]),
    .o_if_stall(if_s[0]), .o_id_stall(id_s[0]), .o_dp_stall(dp_s[0]),
    .o_is_rs_vld(isv[0]), .o_recovering(recov[0]),
    .i_cnt_sel(sel), .o_cnt_val(cv0), .i_cnt_clr(clr));

  pipe_ctrl_unit #(.NUM_FU(NF), .RECOV_CYCLES(0), .CNT_W(32), .SEL_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_dp_freelist_allocable(fl), .i_dp_rs_allocable(rs),
    .i_exfin_prmiss(miss), .i_is_rs_sel_vld(sv), .i_ex_accessable(ex),
    .o_if_kill(if_k[1]), .o_id_kill(id_k[1]), .o_dp_kill(dp_k[1]),
    .o_if_stall(if_s[1]), .o_id_stall(id_s[1]), .o_dp_stall(dp_s[1]),
    .o_is_rs_vld(isv[1]), .o_recovering(recov[1]),
    .i_cnt_sel(sel), .o_cnt_val(cv1), .i_cnt_clr(clr));

  pipe_ctrl_unit #(.NUM_FU(NF), .RECOV_CYCLES(2), .CNT_W(4), .SEL_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_dp_freelist_allocable(fl), .i_dp_rs_allocable(rs),
    .i_exfin_prmiss(miss), .i_is_rs_sel_vld(sv), .i_ex_accessable(ex),
    .o_if_kill(if_k[2]), .o_id_kill(id_k[2]), .o_dp_kill(dp_k[2]),
    .o_if_stall(if_s[2]), .o_id_stall(id_s[2]), .o_dp_stall(dp_s[2]),
    .o_is_rs_vld(isv[2]), .o_recovering(recov[2]),
    .i_cnt_sel(sel), .o_cnt_val(cv2), .i_cnt_clr(clr));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] cval(input int d);
    case (d)
      0:       return 64'(cv0);
      1:       return 64'(cv1);
      default: return 64'(cv2);
    endcase
  endfunction

  task automatic mdl_reset();
    last_miss = cyc - 100;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < NC; k++) mcnt[d][k] = 0;
  endtask

  task automatic idle_in();
    fl = 1'b1; rs = '1; miss = 1'b0; sv = '0; ex = '1; clr = 1'b0;
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance it.
  task automatic step();
    bit res_stall, flush, rcv, kill, stall;
    int since;
    longint inc;
    @(negedge clk);
    res_stall = !(fl && (&rs));
    since = cyc - last_miss;
    for (int d = 0; d < 3; d++) begin
      flush = (since == 1);
      rcv   = (since >= 2) && (since <= 1 + rc[d]);
      kill  = miss || flush;
      stall = res_stall || rcv;
      chk($sformatf("kill%0d", d), {if_k[d], id_k[d], dp_k[d]}, {3{kill}});
      chk($sformatf("stall%0d", d), {if_s[d], id_s[d], dp_s[d]}, {3{stall}});
      chk($sformatf("recov%0d", d), recov[d], flush || rcv);
      chk($sformatf("issue%0d", d), isv[d], sv & ex);
      chk($sformatf("cnt%0d_sel%0d", d, sel), cval(d), (int'(sel) < NC) ? mcnt[d][sel] : 0);
      for (int k = 0; k < NC; k++) begin
        case (k)
          0:       inc = (stall && !kill) ? 1 : 0;
          1:       inc = miss ? 1 : 0;
          2:       inc = (flush || rcv) ? 1 : 0;
          default: inc = (sv[k-3] && !ex[k-3]) ? 1 : 0;
        endcase
        if (clr) mcnt[d][k] = 0;
        else if (mcnt[d][k] + inc <= mx[d]) mcnt[d][k] = mcnt[d][k] + inc;
      end
    end
    if (miss) last_miss = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic read_cnt(input string tag, input int d, input int idx, input longint exp);
    sel = 3'(idx);
    #0.5;
    chk(tag, cval(d), 64'(exp));
  endtask

  initial begin
    idle_in();
    mdl_reset();
    // Reset state: everything quiet, every counter reads zero.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_kill%0d", d), {if_k[d], dp_k[d]}, 2'b00);
      chk($sformatf("rst_stall%0d", d), {if_s[d], dp_s[d]}, 2'b00);
      chk($sformatf("rst_recov%0d", d), recov[d], 1'b0);
    end
    for (int k = 0; k < NC; k++) read_cnt($sformatf("rst_cnt%0d", k), 0, k, 0);
    sel = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single mispredict pulse.
    miss = 1'b1; step(); miss = 1'b0;
    repeat (4) step();
    read_cnt("pulse_cnt1", 0, 1, 1);
    read_cnt("pulse_cnt2", 0, 2, 3);
    read_cnt("rc0_cnt2", 1, 2, 1);

    // Second mispredict in the last RECOVER cycle.
    clr = 1'b1; step(); clr = 1'b0;
    miss = 1'b1; step(); miss = 1'b0;
    repeat (2) step();
    miss = 1'b1; step(); miss = 1'b0;
    repeat (4) step();
    read_cnt("remiss_cnt1", 0, 1, 2);

    // Resource stall for exactly five cycles.
    clr = 1'b1; step(); clr = 1'b0;
    rs = 4'b1011; repeat (5) step();
    rs = 4'b1111; repeat (2) step();
    read_cnt("rs_cnt0", 0, 0, 5);

    // Issue blocking on FU1 and FU3.
    clr = 1'b1; step(); clr = 1'b0;
    sv = 4'b1111; ex = 4'b0101; repeat (3) step();
    idle_in(); step();
    read_cnt("blk_cnt3", 0, 3, 0);
    read_cnt("blk_cnt4", 0, 4, 3);
    read_cnt("blk_cnt5", 0, 5, 0);
    read_cnt("blk_cnt6", 0, 6, 3);

    // Saturation of the narrow build, then clear.
    clr = 1'b1; step(); clr = 1'b0;
    fl = 1'b0; repeat (20) step();
    fl = 1'b1; step();
    read_cnt("sat_cnt0_w4", 2, 0, 15);
    read_cnt("sat_cnt0_w32", 0, 0, 20);
    clr = 1'b1; step(); clr = 1'b0;
    read_cnt("clr_cnt0_w4", 2, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      miss = ($urandom_range(7) == 0);
      fl   = ($urandom_range(9) != 0);
      rs   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      sv   = 4'($urandom);
      ex   = 4'($urandom);
      sel  = 3'($urandom);
      clr  = ($urandom_range(31) == 0);
      step();
    end

    // Reset in the middle of recovery.
    idle_in();
    miss = 1'b1; step(); miss = 1'b0;
    step();
    rst_n = 1'b0;
    #0.5;
    for (int d = 0; d < 3; d++) chk($sformatf("midrst_recov%0d", d), recov[d], 1'b0);
    chk("midrst_stall", dp_s[0], 1'b0);
    for (int k = 0; k < NC; k++) read_cnt($sformatf("midrst_cnt%0d", k), 0, k, 0);
    mdl_reset();
    sel = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rs = 4'b1011; step();
    rs = 4'b1111; repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
